// File: rtl/complete_arb_pkg.sv
// Shared types and helpers for the completion arbiter: completion message layout
// and the modular sequence-number age compare.
package complete_arb_pkg;

  localparam int CMP_SEQ_W  = 8;
  localparam int CMP_ADDR_W = 5;
  localparam int CMP_DATA_W = 32;

  typedef struct packed {
    logic [CMP_SEQ_W-1:0]  seq_num;
    logic [CMP_ADDR_W-1:0] waddr;
    logic [CMP_DATA_W-1:0] wdata;
    logic                  wen;
  } cmp_msg_t;

  // a is older than b when (a - b) is negative in a w-bit two's complement view.
  function automatic logic seq_older(input logic [31:0] a, input logic [31:0] b,
                                     input int unsigned w);
    logic [31:0] diff;
    diff = a - b;
    return diff[5'(w - 32'd1)];
  endfunction

endpackage

// File: rtl/complete_arbiter_rr_arbiter.sv
// Combinational round-robin priority scan starting at ptr; returns a one-hot
// grant, the encoded winner index and whether anything was granted.
module rr_arbiter
  import complete_arb_pkg::*;
#(
  parameter int p_num_pipes = 2,
  parameter int p_ptr_bits  = 1
) (
  input  logic [p_num_pipes-1:0] req,
  input  logic [p_ptr_bits-1:0]  ptr,
  output logic [p_num_pipes-1:0] grant,
  output logic [p_ptr_bits-1:0]  grant_idx,
  output logic                   grant_any
);

  function automatic logic [p_ptr_bits-1:0] scan_idx(input logic [p_ptr_bits-1:0] base,
                                                     input int unsigned offset);
    int unsigned sum;
    sum = (32'(base) + offset) % 32'(p_num_pipes);
    return p_ptr_bits'(sum);
  endfunction

  // First requester found walking ptr, ptr+1, ... wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int unsigned k = 0; k < 32'(p_num_pipes); k++) begin
      if (!grant_any && req[scan_idx(ptr, k)]) begin
        grant[scan_idx(ptr, k)] = 1'b1;
        grant_idx               = scan_idx(ptr, k);
        grant_any               = 1'b1;
      end else begin
      end
    end
  end

endmodule

// File: rtl/complete_arbiter.sv
// Arbitrates execute-pipe completions onto the single registered completion path.
// Define COMPLETE_ARBITER_OLDEST_FIRST_EN to prefer the oldest sequence number.
module complete_arbiter
  import complete_arb_pkg::*;
#(
  parameter int p_num_pipes    = 2,
  parameter int p_seq_num_bits = CMP_SEQ_W
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [p_num_pipes-1:0]              req_val,
  output logic [p_num_pipes-1:0]              req_rdy,
  input  logic [p_num_pipes*p_seq_num_bits-1:0] req_seq_num,
  input  logic [p_num_pipes*5-1:0]            req_waddr,
  input  logic [p_num_pipes*32-1:0]           req_wdata,
  input  logic [p_num_pipes-1:0]              req_wen,
  output logic                                cmp_val,
  output logic [p_seq_num_bits-1:0]           cmp_seq_num,
  output logic [4:0]                          cmp_waddr,
  output logic [31:0]                         cmp_wdata,
  output logic                                cmp_wen,
  output logic [31:0]                         grant_count
);

  localparam int PTR_W = (p_num_pipes > 1) ? $clog2(p_num_pipes) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(p_num_pipes - 1);

  logic [PTR_W-1:0]          ptr_r;
  logic [PTR_W-1:0]          ptr_nxt_s;
  logic [PTR_W-1:0]          win_idx_s;
  logic [p_num_pipes-1:0]    arb_req_s;
  logic [p_num_pipes-1:0]    grant_s;
  logic                      win_any_s;
  logic [p_seq_num_bits-1:0] sel_seq_s;
  logic [4:0]                sel_waddr_s;
  logic [31:0]               sel_wdata_s;
  logic                      sel_wen_s;

`ifdef COMPLETE_ARBITER_OLDEST_FIRST_EN
  logic [p_num_pipes-1:0] oldest_s;

  // Drop any requester that some other valid requester is strictly older than.
  always_comb begin
    oldest_s = req_val;
    for (int i = 0; i < p_num_pipes; i++) begin
      for (int j = 0; j < p_num_pipes; j++) begin
        oldest_s[i] = oldest_s[i] & ~(req_val[j] & seq_older(
                        32'(req_seq_num[j*p_seq_num_bits +: p_seq_num_bits]),
                        32'(req_seq_num[i*p_seq_num_bits +: p_seq_num_bits]),
                        p_seq_num_bits));
      end
    end
  end

  // Fall back to plain round-robin if the in-flight window was violated.
  assign arb_req_s = (|oldest_s) ? oldest_s : req_val;
`else
  assign arb_req_s = req_val;
`endif

  rr_arbiter #(
    .p_num_pipes (p_num_pipes),
    .p_ptr_bits  (PTR_W)
  ) u_rr (
    .req       (arb_req_s),
    .ptr       (ptr_r),
    .grant     (grant_s),
    .grant_idx (win_idx_s),
    .grant_any (win_any_s)
  );

  assign req_rdy = grant_s;

  // One-hot AND-OR select of the winner's fields and the next priority pointer.
  always_comb begin
    sel_seq_s   = '0;
    sel_waddr_s = 5'd0;
    sel_wdata_s = 32'd0;
    sel_wen_s   = 1'b0;
    for (int i = 0; i < p_num_pipes; i++) begin
      sel_seq_s   = sel_seq_s   | (req_seq_num[i*p_seq_num_bits +: p_seq_num_bits]
                                   & {p_seq_num_bits{grant_s[i]}});
      sel_waddr_s = sel_waddr_s | (req_waddr[i*5 +: 5] & {5{grant_s[i]}});
      sel_wdata_s = sel_wdata_s | (req_wdata[i*32 +: 32] & {32{grant_s[i]}});
      sel_wen_s   = sel_wen_s   | (req_wen[i] & grant_s[i]);
    end
    ptr_nxt_s = (win_idx_s == LAST_IDX) ? '0 : win_idx_s + PTR_W'(1);
  end

  // Priority pointer, registered completion notification and grant counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r       <= '0;
      cmp_val     <= 1'b0;
      cmp_seq_num <= '0;
      cmp_waddr   <= 5'd0;
      cmp_wdata   <= 32'd0;
      cmp_wen     <= 1'b0;
      grant_count <= 32'd0;
    end else if (win_any_s) begin
      ptr_r       <= ptr_nxt_s;
      cmp_val     <= 1'b1;
      cmp_seq_num <= sel_seq_s;
      cmp_waddr   <= sel_waddr_s;
      cmp_wdata   <= sel_wdata_s;
      // x0 is hardwired: still report the completion, never write it.
      cmp_wen     <= sel_wen_s & (sel_waddr_s != 5'd0);
      grant_count <= grant_count + 32'd1;
    end else begin
      cmp_val     <= 1'b0;
      cmp_wen     <= 1'b0;
    end
  end

endmodule
